id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 68 ++++++
 rtl/id_ex_reg_if.sv | 65 ++++++
 rtl/id_ex_reg_load_use_detect.sv | 38 +++
 rtl/id_ex_reg.sv | 104 ++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_reg_pkg
// Shared definitions for the ID/EX pipeline register slice:
//   - width of the ID control bundle and the bit position of every field
//   - ALU operation encodings carried in aluOp
//   - the NOP (all-zero) control word used for bubbles
//   - the packed record held by the ID/EX register
//   - a helper that gates a control word with its valid bit
// Optional feature macro used by the slice: ID_EX_BUBBLE_CNT_EN
// ---------------------------------------------------------------------------
package id_ex_reg_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned CTRL_W = 12;

   // Control bundle layout, MSB first:
   // {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, branch, jump, aluOp[3:0]}
   localparam int unsigned CTRL_REGWRITE = 11;
   localparam int unsigned CTRL_MEMREAD  = 10;
   localparam int unsigned CTRL_MEMWRITE = 9;
   localparam int unsigned CTRL_MEMTOREG = 8;
   localparam int unsigned CTRL_ALUSRC   = 7;
   localparam int unsigned CTRL_REGDST   = 6;
   localparam int unsigned CTRL_BRANCH   = 5;
   localparam int unsigned CTRL_JUMP     = 4;
   localparam int unsigned CTRL_ALUOP_HI = 3;
   localparam int unsigned CTRL_ALUOP_LO = 0;

   // ALU operation encodings carried in aluOp[3:0].
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   // A bubble carries no side effects: every control bit clear.
   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   // Contents of the ID/EX register.
   typedef struct packed {
      logic [DATA_W-1:0] pc_plus4;
      logic [DATA_W-1:0] imm_ext;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [IDX_W-1:0]  rs;
      logic [IDX_W-1:0]  rt;
      logic [IDX_W-1:0]  rd;
      logic [CTRL_W-1:0] ctrl;
      logic              valid;
   } ex_stage_t;

   // An invalid slot must never carry control bits downstream.
   function automatic logic [CTRL_W-1:0] ctrl_gate(input logic [CTRL_W-1:0] ctrl,
                                                   input logic              valid);
      return valid ? ctrl : CTRL_NOP;
   endfunction

endpackage : id_ex_reg_pkg

// File: rtl/id_ex_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_reg_if
// Bundles the ID-side inputs and EX-side outputs of the ID/EX register.
//   ID side  : pcPlus4In, immExtIn, rsDataIn, rtDataIn, rsIn, rtIn, rdIn,
//              ctrlIn, idValid, flush
//   EX side  : pcPlus4Out, immExtOut, rsDataOut, rtDataOut, rsOut, rtOut,
//              rdOut, ctrlOut, exValid
//   Upstream : stallUp (combinational hold request for PC and IF/ID)
//   Optional : bubbleCnt, present only with ID_EX_BUBBLE_CNT_EN defined
// Modports:
//   master - the pipeline side that drives ID data and consumes EX data
//   slave  - the id_ex_reg block itself
// Handshake: no valid/ready pair; idValid qualifies the ID slot, exValid
// qualifies the EX slot, and stallUp=1 tells the upstream stages to hold
// their contents for one more cycle so they are presented again.
// ---------------------------------------------------------------------------
interface id_ex_reg_if;
   import id_ex_reg_pkg::*;

   logic [DATA_W-1:0] pcPlus4In;
   logic [DATA_W-1:0] immExtIn;
   logic [DATA_W-1:0] rsDataIn;
   logic [DATA_W-1:0] rtDataIn;
   logic [IDX_W-1:0]  rsIn;
   logic [IDX_W-1:0]  rtIn;
   logic [IDX_W-1:0]  rdIn;
   logic [CTRL_W-1:0] ctrlIn;
   logic              idValid;
   logic              flush;

   logic [DATA_W-1:0] pcPlus4Out;
   logic [DATA_W-1:0] immExtOut;
   logic [DATA_W-1:0] rsDataOut;
   logic [DATA_W-1:0] rtDataOut;
   logic [IDX_W-1:0]  rsOut;
   logic [IDX_W-1:0]  rtOut;
   logic [IDX_W-1:0]  rdOut;
   logic [CTRL_W-1:0] ctrlOut;
   logic              exValid;
   logic              stallUp;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0]       bubbleCnt;
`endif

   modport master (
`ifdef ID_EX_BUBBLE_CNT_EN
      input  bubbleCnt,
`endif
      output pcPlus4In, immExtIn, rsDataIn, rtDataIn,
      output rsIn, rtIn, rdIn, ctrlIn, idValid, flush,
      input  pcPlus4Out, immExtOut, rsDataOut, rtDataOut,
      input  rsOut, rtOut, rdOut, ctrlOut, exValid, stallUp
   );

   modport slave (
`ifdef ID_EX_BUBBLE_CNT_EN
      output bubbleCnt,
`endif
      input  pcPlus4In, immExtIn, rsDataIn, rtDataIn,
      input  rsIn, rtIn, rdIn, ctrlIn, idValid, flush,
      output pcPlus4Out, immExtOut, rsDataOut, rtDataOut,
      output rsOut, rtOut, rdOut, ctrlOut, exValid, stallUp
   );

endinterface : id_ex_reg_if

// File: rtl/id_ex_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. A hazard exists when the
// EX slot holds a valid load whose destination (rt) is a non-zero register
// that the valid instruction in ID reads as rs or rt.
// Ports:
//   ex_valid_i     EX slot holds a real instruction
//   ex_mem_read_i  EX instruction is a load
//   ex_rt_i        EX load destination index
//   id_valid_i     ID slot holds a real instruction
//   id_rs_i        ID source index rs
//   id_rt_i        ID source index rt
//   load_use_o     hazard present this cycle
// ---------------------------------------------------------------------------
module load_use_detect
   import id_ex_reg_pkg::*;
(
   input  logic             ex_valid_i,
   input  logic             ex_mem_read_i,
   input  logic [IDX_W-1:0] ex_rt_i,
   input  logic             id_valid_i,
   input  logic [IDX_W-1:0] id_rs_i,
   input  logic [IDX_W-1:0] id_rt_i,
   output logic             load_use_o
);

   logic ex_is_load;
   logic dest_nonzero;
   logic src_match;

   assign ex_is_load   = ex_valid_i & ex_mem_read_i;
   // r0 is hard-wired zero, so a load into it can never feed a consumer.
   assign dest_nonzero = (ex_rt_i != '0);
   assign src_match    = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);

   assign load_use_o = ex_is_load & dest_nonzero & id_valid_i & src_match;

endmodule : load_use_detect

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with load-use bubble insertion and flush.
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   bus   id_ex_reg_if.slave: ID-side inputs, registered EX-side outputs,
//         combinational stallUp, optional bubbleCnt
// Per-edge priority: rst > flush > load-use > normal capture.
//   flush    : EX slot becomes a bubble (everything zero)
//   load-use : EX slot becomes a bubble; ID is not captured, stallUp makes
//              upstream present the same instruction again next cycle
//   normal   : all ID fields captured; ctrl is zeroed when idValid=0
// Every registered output comes straight from a flop (one-cycle latency).
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add bubbleCnt, a 32-bit
// wrapping count of edges where flush or load-use inserted a bubble
// (reset itself does not count).
// ---------------------------------------------------------------------------
module id_ex_reg
   import id_ex_reg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   id_ex_reg_if.slave bus
);

   ex_stage_t ex_q;
   ex_stage_t ex_d;
   logic      load_use;
   logic      insert_bubble;

   // Hazard detection looks at the registered EX slot and the live ID slot.
   load_use_detect u_load_use_detect (
      .ex_valid_i    (ex_q.valid),
      .ex_mem_read_i (ex_q.ctrl[CTRL_MEMREAD]),
      .ex_rt_i       (ex_q.rt),
      .id_valid_i    (bus.idValid),
      .id_rs_i       (bus.rsIn),
      .id_rt_i       (bus.rtIn),
      .load_use_o    (load_use)
   );

   // A flush already squashes the ID instruction, so holding upstream for
   // a load-use hazard would be pointless; flush suppresses the stall.
   assign bus.stallUp   = load_use & ~bus.flush;
   assign insert_bubble = bus.flush | load_use;

   always_comb begin
      ex_d = '0;
      if (!insert_bubble) begin
         ex_d.pc_plus4 = bus.pcPlus4In;
         ex_d.imm_ext  = bus.immExtIn;
         ex_d.rs_data  = bus.rsDataIn;
         ex_d.rt_data  = bus.rtDataIn;
         ex_d.rs       = bus.rsIn;
         ex_d.rt       = bus.rtIn;
         ex_d.rd       = bus.rdIn;
         ex_d.ctrl     = ctrl_gate(bus.ctrlIn, bus.idValid);
         ex_d.valid    = bus.idValid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.pcPlus4Out = ex_q.pc_plus4;
   assign bus.immExtOut  = ex_q.imm_ext;
   assign bus.rsDataOut  = ex_q.rs_data;
   assign bus.rtDataOut  = ex_q.rt_data;
   assign bus.rsOut      = ex_q.rs;
   assign bus.rtOut      = ex_q.rt;
   assign bus.rdOut      = ex_q.rd;
   assign bus.ctrlOut    = ex_q.ctrl;
   assign bus.exValid    = ex_q.valid;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] bubble_cnt_d;

   // Natural 32-bit overflow gives the wrap from all-ones to zero.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (insert_bubble) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.bubbleCnt = bubble_cnt_q;
`endif

endmodule : id_ex_reg
